// File: rtl/i2c_reg_master.sv
// i2c_reg_master: single-master I2C register read/write initiator with clock-stretch timeout
module i2c_reg_master #(
  parameter int CLK_DIV = 25,
  parameter int STRETCH_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [6:0]  cmd_dev_addr,
  input  logic [7:0]  cmd_reg_addr,
  input  logic [1:0]  cmd_len,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        done,
  output logic [1:0]  err,
  output logic        busy,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        scl_oe,
  output logic        sda_oe
);
  localparam int CW = $clog2(CLK_DIV + 2);
  localparam int TW = $clog2(STRETCH_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_N = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_W = CW'(CLK_DIV + 1);
  localparam logic [TW-1:0] T_MAX = TW'(STRETCH_TIMEOUT);
  typedef enum logic [3:0] {IDLE, START, ADDR_W, REG, WDATA, RSTART, ADDR_R, RDATA, STOP, FIN} state_t;
  state_t state, state_n;
  logic [1:0] phase, len, err_n, scl_q, sda_q, byten;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [3:0] bitn;
  logic [7:0] sh, tx, reg_a;
  logic [6:0] dev;
  logic [31:0] wd;
  logic rw, nack, scl_s, sda_s, in_byte, st_unit, wait_p, adv, last, stall, abort, unit_end;
  assign scl_s = scl_q[1];
  assign sda_s = sda_q[1];
  assign cmd_ready = state == IDLE;
  assign busy = state != IDLE;
  assign done = state == FIN;
  // Release phases carry a 2-cycle preamble covering synchronizer latency, then count only while SCL reads high
  always_comb begin
    in_byte = state inside {ADDR_W, REG, WDATA, ADDR_R, RDATA};
    st_unit = state == START || state == RSTART;
    wait_p = in_byte ? phase == 2'd2 : st_unit ? phase == 2'd0 : state == STOP && phase == 2'd1;
    adv = !wait_p || cnt < CW'(2) || scl_s;
    last = adv && cnt == (wait_p ? LAST_W : LAST_N);
    stall = wait_p && !adv;
    abort = stall && tcnt == T_MAX;
    unit_end = last && phase == 2'd3;
    tx = state == ADDR_W ? {dev, 1'b0} : state == ADDR_R ? {dev, 1'b1} : state == REG ? reg_a :
         state == WDATA ? wd[{byten, 3'b000} +: 8] : 8'hFF;
    scl_oe = in_byte ? !phase[1] : state == STOP && phase == 2'd0;
    sda_oe = in_byte ? (bitn[3] ? state == RDATA && byten != len : !tx[3'd7 - bitn[2:0]]) :
             st_unit ? phase[1] : state == STOP && phase != 2'd3;
  end
  always_comb begin
    state_n = state;
    err_n = err;
    if (state == IDLE) begin
      if (cmd_valid) begin
        state_n = START;
        err_n = 2'd0;
      end
    end else if (abort) begin
      state_n = FIN;
      err_n = 2'd3;
    end else if (state == FIN) begin
      state_n = IDLE;
    end else if (unit_end && (!in_byte || bitn[3])) begin
      case (state)
        START:   state_n = ADDR_W;
        RSTART:  state_n = ADDR_R;
        STOP:    state_n = FIN;
        ADDR_W:  state_n = nack ? STOP : REG;
        ADDR_R:  state_n = nack ? STOP : RDATA;
        REG:     state_n = nack ? STOP : rw ? RSTART : WDATA;
        WDATA:   state_n = nack || byten == len ? STOP : WDATA;
        RDATA:   state_n = byten == len ? STOP : RDATA;
        default: state_n = state;
      endcase
      if (nack && state inside {ADDR_W, ADDR_R}) err_n = 2'd1;
      if (nack && state inside {REG, WDATA}) err_n = 2'd2;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      cnt <= '0;
      tcnt <= '0;
      bitn <= '0;
      byten <= '0;
      err <= '0;
      rd_data <= '0;
      scl_q <= 2'b11;
      sda_q <= 2'b11;
    end else begin
      scl_q <= {scl_q[0], scl_i};
      sda_q <= {sda_q[0], sda_i};
      state <= state_n;
      err <= err_n;
      tcnt <= stall ? tcnt + TW'(1) : '0;
      cnt <= (last || state == IDLE) ? '0 : cnt + CW'(adv);
      phase <= state == IDLE ? 2'd0 : phase + 2'(last);
      if (state == IDLE) begin
        bitn <= '0;
        byten <= '0;
      end else if (unit_end && in_byte) begin
        bitn <= bitn[3] ? 4'd0 : bitn + 4'd1;
        if (bitn[3]) byten <= state_n == state ? byten + 2'd1 : 2'd0;
      end
      if (in_byte && phase == 2'd2 && last) begin
        if (bitn[3]) nack <= sda_s;
        else sh <= {sh[6:0], sda_s};
      end
      if (state == RDATA && unit_end && bitn[3]) rd_data[{byten, 3'b000} +: 8] <= sh;
      if (state == IDLE && cmd_valid) begin
        rw <= cmd_rw;
        dev <= cmd_dev_addr;
        reg_a <= cmd_reg_addr;
        len <= cmd_len;
        wd <= wr_data;
        rd_data <= '0;
      end
    end
  end
endmodule

// File: doc/i2c_reg_master.md
# i2c_reg_master

I2C initiator (single-master, 7-bit addressing) that executes register-write and register-read transactions against the board's I2C register-file responders, including the safety FPGA register map. It accepts one command at a time over a valid/ready handshake. It drives open-drain SCL/SDA enables, honours responder clock stretching with a timeout, and returns read data plus an error code.

## Interface
- CLK_DIV, 25: clk cycles per quarter-bit phase (must be ≥ 2).
- STRETCH_TIMEOUT, 100000: max clk cycles a released SCL may be held low before abort.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted on cmd_valid && cmd_ready.
- cmd_rw  in  1  0 = register write, 1 = register read.
- cmd_dev_addr  in  7  target device address.
- cmd_reg_addr  in  8  first register address.
- cmd_len  in  2  byte count minus 1 (1–4 bytes).
- wr_data  in  32  write bytes, little-endian: [7:0] goes to reg_addr, [15:8] to reg_addr+1, and so on.
- rd_data  out  32  read bytes in the same order; bytes not read are 0.
- done  out  1  one-cycle pulse at transaction end.
- err  out  2  valid with done: 0 ok, 1 address NACK, 2 data/register NACK, 3 stretch timeout.
- busy  out  1  high from acceptance through done.
- scl_i, sda_i  in  1  bus line levels, each through a 2-FF synchronizer.
- scl_oe, sda_oe  out  1  1 = pull line low, 0 = release.

## Operation
- Reset values: scl_oe=0, sda_oe=0, cmd_ready=1 (after reset deasserts), busy=0, done=0, err=0, rd_data=0. A reset mid-transaction releases both lines on the next cycle and discards the command; no stop is generated.
- On acceptance the block latches all cmd_* fields and wr_data, clears rd_data, and sets busy.
- States:
  - IDLE → START → ADDR_W → REG.
  - For a write, REG → WDATA ×len → STOP.
  - For a read, REG → RSTART → ADDR_R → RDATA ×len → STOP.
  - STOP → IDLE.
- Bits are sent MSB first. Each byte has 8 data bits plus 1 ACK bit. The address bytes are {dev_addr,0} for write and {dev_addr,1} for read.
- Bit unit (4 phases of CLK_DIV cycles):
  - P0: SCL low; SDA updates on the first cycle.
  - P1: SCL low.
  - P2: SCL released. The phase counter advances only while synchronized scl_i=1. SDA is sampled on the last cycle of P2.
  - P3: SCL high.
- ACK handling:
  - In ADDR_W, REG, WDATA and ADDR_R, SDA is released in the ACK bit. A sampled 1 is a NACK.
  - In RDATA, the master drives ACK (sda_oe=1) after every byte except the last and NACKs the last byte (releases SDA).
- START/RSTART unit:
  - P0: release SDA and SCL; wait for SCL high.
  - P1: hold.
  - P2: sda_oe=1.
  - P3: hold.
  - The following bit's P0 pulls SCL low.
- STOP unit:
  - P0: SCL low, sda_oe=1.
  - P1: release SCL; wait for SCL high.
  - P2: hold.
  - P3: release SDA.
  - done is asserted the cycle after P3 ends.
- NACK: skip the remaining bytes, go to STOP, and report err 1 (address byte, either direction) or 2 (register or write-data byte). rd_data keeps the bytes completed so far.
- Stretch timeout: if any SCL-release wait exceeds STRETCH_TIMEOUT cycles, release both lines immediately, skip STOP, pulse done with err=3, and return to IDLE.
- No multi-master arbitration; sda_i is not compared during master-driven bits.

## Timing
- The synchronizer adds 2 cycles to every SCL-release phase. On an unstretched bus, each unit (bit, START, RSTART, STOP) takes 4·CLK_DIV+2 cycles.
- Write of L bytes: acceptance to done = (2+9·(2+L))·(4·CLK_DIV+2) + 1 cycles.
- Read of L bytes: acceptance to done = (3+9·(3+L))·(4·CLK_DIV+2) + 1 cycles.
- cmd_ready falls the cycle after acceptance. It rises the cycle after done, and a new command may be accepted that cycle.
- rd_data is stable from done until the next acceptance.
- Stretching extends only the P2 (or release) phase, by the number of cycles SCL stays low.

## Test plan
- Write, CLK_DIV=4, dev 0x50, reg 0x10, len 1 (cmd_len=1, 2 bytes), wr_data 0x2750, responder model ACKs all: bus carries A0, 10, 50, 27. done arrives 685 cycles after acceptance with err=0. Model registers: 0x10=0x50, 0x11=0x27.
- Read, reg 0x1A, cmd_len=1: bus carries A0, 1A, Sr, A1, then 2 bytes from the model (0xBE, 0xEF), with master ACK then NACK, then stop. rd_data=0x0000EFBE and err=0.
- Address NACK (no device at 0x51): exactly 1 byte is transferred, then stop. done with err=1; rd_data=0.
- Responder stretches SCL for 4000 cycles on the first ACK bit: completion is delayed by exactly 4000 cycles, data is correct, and err=0.
- SCL held low for STRETCH_TIMEOUT+1 cycles: scl_oe=0 and sda_oe=0 on the next cycle, done with err=3, and cmd_ready=1 the following cycle.
- rst asserted mid-WDATA: on the next cycle scl_oe=0, sda_oe=0, busy=0, and done is not pulsed. A subsequent write completes correctly.
